program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 129 ++++++++++++
 tb/tb_program_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: parses 0xA5-framed instruction packets, writes each
// 28-bit instruction to instruction memory and holds the CPU in reset until a good load.
module program_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            iData,
  input  logic                  iValid,
  output logic                  oReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [27:0]           oInstruction,
  output logic                  oCpuReset,
  output logic                  oDone,
  output logic                  oError
);

  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [7:0]            idx_q, idx_d;
  logic [1:0]            pos_q, pos_d;
  logic [19:0]           asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [27:0]           instr_q, instr_d;
  logic                  accept;

  assign accept = iValid && (state_q != S_WRITE);

  // The first byte contributes only its low nibble (its high nibble must be zero),
  // so 20 bits of history plus the fourth byte form the full 28-bit word.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    waddr_d = waddr_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (accept && iData == HEADER) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (accept) begin
          if (iData == 8'd0) begin
            state_d = S_ERROR;
          end else begin
            count_d = iData;
            idx_d   = '0;
            pos_d   = '0;
            csum_d  = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (pos_q == 2'd0 && iData[7:4] != 4'd0) begin
            state_d = S_ERROR;
          end else begin
            asm_d  = {asm_q[11:0], iData};
            csum_d = csum_q ^ iData;
            pos_d  = pos_q + 2'd1;
            if (pos_q == 2'd3) begin
              waddr_d = START_ADDR + ADDR_WIDTH'(idx_q);
              instr_d = {asm_q, iData};
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 8'd1;
        if ((9'(idx_q) + 9'd1) < 9'(count_q)) state_d = S_DATA;
        else                                    state_d = S_CHECK;
      end
      S_CHECK: begin
        if (accept) state_d = (iData == csum_q) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (accept && iData == HEADER) state_d = S_COUNT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      waddr_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      waddr_q <= waddr_d;
      instr_q <= instr_d;
    end
  end

  assign oReady        = (state_q != S_WRITE);
  assign oWriteEnable  = (state_q == S_WRITE);
  assign oWriteAddress = waddr_q;
  assign oInstruction  = instr_q;
  assign oCpuReset     = (state_q != S_DONE);
  assign oDone         = (state_q == S_DONE);
  assign oError        = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: dut0 loads at address 0, dut1 at 0xFFFF to
// exercise address wrap; expected writes are queued before the frame is sent.
module tb_program_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [27:0] instr;
  } wr_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  data  = 8'h00;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        ready0, we0, cpurst0, done0, err0;
  logic        ready1, we1, cpurst1, done1, err1;
  logic [15:0] addr0, addr1;
  logic [27:0] instr0, instr1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_cnt0 = 0;
  int wr_cnt1 = 0;
  wr_t exp_q0[$];
  wr_t exp_q1[$];

  always #5 Clock = ~Clock;

  program_loader #(.ADDR_WIDTH(16), .START_ADDR(16'h0000)) dut0 (
    .Clock(Clock), .Reset(Reset), .iData(data), .iValid(valid0), .oReady(ready0),
    .oWriteEnable(we0), .oWriteAddress(addr0), .oInstruction(instr0),
    .oCpuReset(cpurst0), .oDone(done0), .oError(err0));

  program_loader #(.ADDR_WIDTH(16), .START_ADDR(16'hFFFF)) dut1 (
    .Clock(Clock), .Reset(Reset), .iData(data), .iValid(valid1), .oReady(ready1),
    .oWriteEnable(we1), .oWriteAddress(addr1), .oInstruction(instr1),
    .oCpuReset(cpurst1), .oDone(done1), .oError(err1));

  // Write monitor: every strobe must match the head of the scoreboard and show oReady=0.
  always @(negedge Clock) begin
    wr_t e;
    if (we0 === 1'b1) begin
      wr_cnt0++;
      total_cnt++;
      if (exp_q0.size() == 0) $display("FAIL dut0_write unexpected addr=%h instr=%h", addr0, instr0);
      else begin
        e = exp_q0.pop_front();
        if (addr0 !== e.addr || instr0 !== e.instr)
          $display("FAIL dut0_write got addr=%h instr=%h exp addr=%h instr=%h", addr0, instr0, e.addr, e.instr);
        else pass_cnt++;
      end
      total_cnt++;
      if (ready0 !== 1'b0) $display("FAIL dut0_ready_in_write got=%b exp=0", ready0); else pass_cnt++;
    end
    if (we1 === 1'b1) begin
      wr_cnt1++;
      total_cnt++;
      if (exp_q1.size() == 0) $display("FAIL dut1_write unexpected addr=%h instr=%h", addr1, instr1);
      else begin
        e = exp_q1.pop_front();
        if (addr1 !== e.addr || instr1 !== e.instr)
          $display("FAIL dut1_write got addr=%h instr=%h exp addr=%h instr=%h", addr1, instr1, e.addr, e.instr);
        else pass_cnt++;
      end
      total_cnt++;
      if (ready1 !== 1'b0) $display("FAIL dut1_ready_in_write got=%b exp=0", ready1); else pass_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_valid(input int which, input logic v);
    if (which == 0) valid0 = v; else valid1 = v;
  endtask

  // Presents one byte and holds it until an edge where oReady was high.
  task automatic send_byte(input int which, input logic [7:0] b);
    logic r;
    int   budget = 0;
    @(negedge Clock);
    data = b;
    set_valid(which, 1'b1);
    do begin
      r = (which == 0) ? ready0 : ready1;
      @(posedge Clock);
      #1;
      budget++;
    end while (!r && budget < 20);
    if (!r) begin
      total_cnt++;
      $display("FAIL handshake_timeout dut%0d byte=%h", which, b);
    end
  endtask

  task automatic send_stream(input int which, input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(negedge Clock);
        set_valid(which, 1'b0);
      end
      send_byte(which, bytes[i]);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(negedge Clock);
      valid0 = 1'b0;
      valid1 = 1'b0;
    end
  endtask

  function automatic logic [7:0] xor_bytes(input logic [7:0] bytes[$]);
    logic [7:0] x = 8'h00;
    foreach (bytes[i]) x ^= bytes[i];
    return x;
  endfunction

  task automatic test_reset();
    Reset = 1'b0;
    #3;
    total_cnt++; if (ready0 !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready0); else pass_cnt++;
    total_cnt++; if (we0 !== 1'b0) $display("FAIL reset_we got=%b exp=0", we0); else pass_cnt++;
    total_cnt++; if (addr0 !== 16'h0) $display("FAIL reset_addr got=%h exp=0000", addr0); else pass_cnt++;
    total_cnt++; if (instr0 !== 28'h0) $display("FAIL reset_instr got=%h exp=0", instr0); else pass_cnt++;
    total_cnt++; if (cpurst0 !== 1'b1) $display("FAIL reset_cpurst got=%b exp=1", cpurst0); else pass_cnt++;
    total_cnt++; if ({done0, err0} !== 2'b00) $display("FAIL reset_done_err got=%b exp=00", {done0, err0}); else pass_cnt++;
    total_cnt++; if ({ready1, we1, cpurst1, done1, err1} !== 5'b10100) $display("FAIL reset_dut1 got=%b exp=10100", {ready1, we1, cpurst1, done1, err1}); else pass_cnt++;
    @(negedge Clock);
    Reset = 1'b1;
    settle(2);
  endtask

  // Checksum is the XOR of the eight instruction bytes, which is 0x00 for this frame.
  task automatic test_good_frame();
    logic [7:0] body[$];
    logic [7:0] f[$];
    int w0 = wr_cnt0;
    body = '{8'h01, 8'h03, 8'h00, 8'h05, 8'h04, 8'h00, 8'h01, 8'h02};
    f = '{8'hA5, 8'h02};
    f = {f, body, xor_bytes(body)};
    exp_q0.push_back('{addr: 16'h0000, instr: 28'h1030005});
    exp_q0.push_back('{addr: 16'h0001, instr: 28'h4000102});
    send_stream(0, f, 1'b1);
    settle(3);
    total_cnt++; if (wr_cnt0 - w0 !== 2) $display("FAIL good_write_count got=%0d exp=2", wr_cnt0 - w0); else pass_cnt++;
    total_cnt++; if (exp_q0.size() !== 0) $display("FAIL good_pending got=%0d exp=0", exp_q0.size()); else pass_cnt++;
    total_cnt++; if (done0 !== 1'b1) $display("FAIL good_done got=%b exp=1", done0); else pass_cnt++;
    total_cnt++; if (cpurst0 !== 1'b0) $display("FAIL good_cpurst got=%b exp=0", cpurst0); else pass_cnt++;
    total_cnt++; if (err0 !== 1'b0) $display("FAIL good_error got=%b exp=0", err0); else pass_cnt++;
    total_cnt++; if ({addr0, instr0} !== {16'h0001, 28'h4000102}) $display("FAIL good_hold got addr=%h instr=%h exp addr=0001 instr=4000102", addr0, instr0); else pass_cnt++;
  endtask

  task automatic test_restart_bad_checksum();
    logic [7:0] f[$];
    int w0;
    f = '{8'hA5};
    send_stream(0, f, 1'b0);
    settle(1);
    total_cnt++; if ({done0, cpurst0} !== 2'b01) $display("FAIL restart_flags got=%b exp=01", {done0, cpurst0}); else pass_cnt++;
    w0 = wr_cnt0;
    f = '{8'h02, 8'h01, 8'h03, 8'h00, 8'h05, 8'h04, 8'h00, 8'h01, 8'h02, 8'h07};
    exp_q0.push_back('{addr: 16'h0000, instr: 28'h1030005});
    exp_q0.push_back('{addr: 16'h0001, instr: 28'h4000102});
    send_stream(0, f, 1'b1);
    settle(3);
    total_cnt++; if (wr_cnt0 - w0 !== 2) $display("FAIL badsum_write_count got=%0d exp=2", wr_cnt0 - w0); else pass_cnt++;
    total_cnt++; if ({err0, done0, cpurst0} !== 3'b101) $display("FAIL badsum_flags got=%b exp=101", {err0, done0, cpurst0}); else pass_cnt++;
  endtask

  task automatic test_zero_count();
    logic [7:0] f[$];
    int w0 = wr_cnt0;
    f = '{8'hA5, 8'h00};
    send_stream(0, f, 1'b0);
    settle(2);
    total_cnt++; if (wr_cnt0 - w0 !== 0) $display("FAIL zero_write_count got=%0d exp=0", wr_cnt0 - w0); else pass_cnt++;
    total_cnt++; if ({err0, done0} !== 2'b10) $display("FAIL zero_flags got=%b exp=10", {err0, done0}); else pass_cnt++;
    test_good_frame();
  endtask

  task automatic test_bad_opcode();
    logic [7:0] f[$];
    int w0;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    w0 = wr_cnt0;
    f = '{8'h12, 8'h34, 8'hA5, 8'h01, 8'hF1};
    send_stream(0, f, 1'b0);
    total_cnt++; if (err0 !== 1'b1) $display("FAIL opcode_error got=%b exp=1", err0); else pass_cnt++;
    f = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(0, f, 1'b0);
    settle(3);
    total_cnt++; if (wr_cnt0 - w0 !== 0) $display("FAIL opcode_write_count got=%0d exp=0", wr_cnt0 - w0); else pass_cnt++;
    total_cnt++; if ({err0, done0, cpurst0} !== 3'b101) $display("FAIL opcode_flags got=%b exp=101", {err0, done0, cpurst0}); else pass_cnt++;
  endtask

  task automatic test_a5_as_data();
    logic [7:0] body[$];
    logic [7:0] f[$];
    body = '{8'h00, 8'hA5, 8'hA5, 8'hA5};
    f = '{8'hA5, 8'h01};
    f = {f, body, xor_bytes(body)};
    exp_q0.push_back('{addr: 16'h0000, instr: 28'h0A5A5A5});
    send_stream(0, f, 1'b1);
    settle(3);
    total_cnt++; if (exp_q0.size() !== 0) $display("FAIL a5data_pending got=%0d exp=0", exp_q0.size()); else pass_cnt++;
    total_cnt++; if ({done0, err0} !== 2'b10) $display("FAIL a5data_flags got=%b exp=10", {done0, err0}); else pass_cnt++;
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] body[$];
    logic [7:0] f[$];
    int w1 = wr_cnt1;
    body = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    f = '{8'hA5, 8'h02};
    f = {f, body, xor_bytes(body)};
    exp_q1.push_back('{addr: 16'hFFFF, instr: 28'h1020304});
    exp_q1.push_back('{addr: 16'h0000, instr: 28'h5060708});
    send_stream(1, f, 1'b0);
    settle(3);
    total_cnt++; if (wr_cnt1 - w1 !== 2) $display("FAIL wrap_write_count got=%0d exp=2", wr_cnt1 - w1); else pass_cnt++;
    total_cnt++; if ({done1, err1, cpurst1} !== 3'b100) $display("FAIL wrap_flags got=%b exp=100", {done1, err1, cpurst1}); else pass_cnt++;
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] f[$];
    int w0 = wr_cnt0;
    f = '{8'hA5, 8'h01, 8'h01, 8'h02};
    send_stream(0, f, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    total_cnt++; if ({ready0, we0, cpurst0, done0, err0} !== 5'b10100) $display("FAIL midrst_flags got=%b exp=10100", {ready0, we0, cpurst0, done0, err0}); else pass_cnt++;
    total_cnt++; if ({addr0, instr0} !== 44'h0) $display("FAIL midrst_regs got addr=%h instr=%h exp 0", addr0, instr0); else pass_cnt++;
    @(negedge Clock);
    Reset = 1'b1;
    f = '{8'h03, 8'h04, 8'h00};
    send_stream(0, f, 1'b0);
    settle(3);
    total_cnt++; if (wr_cnt0 - w0 !== 0) $display("FAIL midrst_write_count got=%0d exp=0", wr_cnt0 - w0); else pass_cnt++;
    total_cnt++; if ({done0, err0, cpurst0} !== 3'b001) $display("FAIL midrst_idle got=%b exp=001", {done0, err0, cpurst0}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_restart_bad_checksum();
    test_zero_count();
    test_bad_opcode();
    test_a5_as_data();
    test_back_to_back_wrap();
    test_mid_frame_reset();
    settle(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
